// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_master_arbiter
// Description : Round-robin sharing of one AHB-Lite master port among
//               NUM_REQ requesters, issuing pipelined SINGLE transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]    req_size,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            HADDR,
  output logic                             HWRITE,
  output logic [SIZE_WIDTH-1:0]            HSIZE,
  output logic [2:0]                       HBURST,
  output logic [1:0]                       HTRANS,
  output logic [DATA_WIDTH-1:0]            HWDATA,
  output logic [3:0]                       HPROT,
  output logic                             HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]            HRDATA,
  input  logic                             HREADY,
  input  logic                             HRESP
);

  localparam int               c_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_REQ - 1);
  localparam logic [1:0]       c_IDLE   = 2'b00;
  localparam logic [1:0]       c_NONSEQ = 2'b10;

  logic [c_PTR_W-1:0]    r_ptr;
  logic                  r_hold;
  logic                  r_a_valid;
  logic [c_PTR_W-1:0]    r_a_owner;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic                  r_a_write;
  logic [SIZE_WIDTH-1:0] r_a_size;
  logic [DATA_WIDTH-1:0] r_a_wdata;
  logic                  r_d_valid;
  logic [c_PTR_W-1:0]    r_d_owner;
  logic                  r_d_write;
  logic [DATA_WIDTH-1:0] r_d_wdata;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_found;
  logic [c_PTR_W-1:0]    w_winner;
  logic [c_PTR_W:0]      w_sum;
  logic                  w_ready_ok;
  logic                  w_accept;
  logic                  w_err_done;
  logic [c_PTR_W-1:0]    w_next_ptr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [SIZE_WIDTH-1:0] w_sel_size;
  logic                  w_sel_write;

  // Error completion keeps the address-phase payload, so nothing may be accepted over it.
  assign w_err_done = HRESP & r_d_valid;
  assign w_ready_ok = HREADY & ~r_hold & ~HRESET & ~w_err_done;
  assign w_accept   = w_found & w_ready_ok;
  assign w_next_ptr = (w_winner == c_LAST) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_sum       = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_size  = '0;
    w_sel_write = 1'b0;
    req_ready   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (c_PTR_W+1)'(k);
      if (w_sum >= (c_PTR_W+1)'(NUM_REQ))
        w_sum = w_sum - (c_PTR_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_sum[c_PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[c_PTR_W-1:0];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (c_PTR_W'(k) == w_winner) begin
        w_sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_size  = req_size[k*SIZE_WIDTH +: SIZE_WIDTH];
        w_sel_write = req_write[k];
      end
    end
    if (w_accept)
      req_ready[w_winner] = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ptr       <= '0;
      r_hold      <= 1'b0;
      r_a_valid   <= 1'b0;
      r_a_owner   <= '0;
      r_a_addr    <= '0;
      r_a_write   <= 1'b0;
      r_a_size    <= '0;
      r_a_wdata   <= '0;
      r_d_valid   <= 1'b0;
      r_d_owner   <= '0;
      r_d_write   <= 1'b0;
      r_d_wdata   <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (HREADY) begin
        r_hold <= 1'b0;
        if (r_d_valid) begin
          r_rsp_valid[r_d_owner] <= 1'b1;
          r_rsp_rdata            <= r_d_write ? '0 : HRDATA;
          r_rsp_err              <= HRESP;
        end
        if (w_err_done) begin
          r_d_valid <= 1'b0;
        end else begin
          r_d_valid <= r_a_valid;
          if (r_a_valid) begin
            r_d_owner <= r_a_owner;
            r_d_write <= r_a_write;
            r_d_wdata <= r_a_write ? r_a_wdata : '0;
          end
          r_a_valid <= w_accept;
          if (w_accept) begin
            r_a_owner <= w_winner;
            r_a_addr  <= w_sel_addr;
            r_a_write <= w_sel_write;
            r_a_size  <= w_sel_size;
            r_a_wdata <= w_sel_wdata;
            r_ptr     <= w_next_ptr;
          end
        end
      end else if (HRESP && r_d_valid) begin
        // First error cycle: idle the bus for the second cycle.
        r_hold <= 1'b1;
      end
    end
  end

  assign HADDR     = r_a_addr;
  assign HWRITE    = r_a_write;
  assign HSIZE     = r_a_size;
  assign HTRANS    = (r_a_valid && !r_hold) ? c_NONSEQ : c_IDLE;
  assign HWDATA    = r_d_wdata;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_master_arbiter
// Description : Vector table, directed corner sequences and a randomized run
//               against a transaction-level model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 3;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_size;
  logic [DW-1:0]   rsp_rdata, HWDATA, HRDATA;
  logic            rsp_err, HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [AW-1:0]   HADDR;
  logic [SW-1:0]   HSIZE;
  logic [2:0]      HBURST;
  logic [1:0]      HTRANS;
  logic [3:0]      HPROT;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] sz);
    req_write[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
    req_size[i*SW +: SW]    = sz;
  endtask

  task automatic reset_dut();
    HRESET = 1'b1; req_valid = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    tick(); tick();
    HRESET = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic         hr;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    logic         exp_nonseq;
  } vec_t;

  typedef struct {
    logic          v;
    int            owner;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] size;
  } txn_t;

  typedef struct {
    logic          v;
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  vec_t tbl[14];
  txn_t pend[N];
  txn_t a_s, d_s;
  rsp_t er, nxt;
  int   ptr, win, errst;
  logic m_hold;
  logic [N-1:0] exp_ready;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0000, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0010, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b1};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0100, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 4'b0000, 1'b1};
    tbl[10] = '{4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0};

    req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;

    // T1: reset held three cycles with all requesters asking
    HRESET = 1'b1; req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_ready", req_ready, '0);
      chk("rst_rsp", rsp_valid, '0);
      tick();
    end
    HRESET = 1'b0; req_valid = '0;
    chk("const_hburst_hprot", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});

    // T2 and simple stalls: cycle vector table
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h1000 + 32'(i * 16), '0, 3'd2);
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].rv; HREADY = tbl[i].hr;
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_rsp", i), rsp_valid, tbl[i].exp_rsp);
      chk($sformatf("tbl%0d_htrans", i), HTRANS, tbl[i].exp_nonseq ? 2'b10 : 2'b00);
      tick();
    end

    // T3 + T4: write then read with two wait states in the write data phase
    reset_dut();
    set_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'd2);
    set_req(1, 1'b0, 32'h100, 32'h0, 3'd2);
    req_valid = 4'b0001; #1;
    chk("t3_ready0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010; #1;
    chk("t3_ready1", req_ready, 4'b0010);
    chk("t3_wr_addr", {HTRANS, HADDR, HWRITE}, {2'b10, 32'h100, 1'b1});
    tick();
    req_valid = 4'b0100; HREADY = 1'b0; #1;
    chk("t3_hwdata", HWDATA, 32'hDEADBEEF);
    chk("t4_ready_wait", req_ready, '0);
    tick();
    #1;
    chk("t4_frozen", {HTRANS, HADDR, HWRITE, HSIZE, HWDATA}, {2'b10, 32'h100, 1'b0, 3'd2, 32'hDEADBEEF});
    chk("t4_no_rsp", rsp_valid, '0);
    tick();
    req_valid = '0; HREADY = 1'b1; #1;
    chk("t4_still_frozen", {HTRANS, HADDR, HWDATA}, {2'b10, 32'h100, 32'hDEADBEEF});
    chk("t4_no_rsp2", rsp_valid, '0);
    tick();
    HRDATA = 32'hDEADBEEF; #1;
    chk("t3_wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {4'b0001, 1'b0, 32'h0});
    tick();
    HRDATA = '0; #1;
    chk("t3_rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, {4'b0010, 1'b0, 32'hDEADBEEF});

    // T5: two-cycle error on req2 with req3 waiting in the address phase
    reset_dut();
    set_req(2, 1'b0, 32'h200, 32'h0, 3'd2);
    set_req(3, 1'b1, 32'h300, 32'h33, 3'd1);
    req_valid = 4'b0100; #1;
    chk("t5_ready2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1000; #1;
    chk("t5_ready3", req_ready, 4'b1000);
    tick();
    req_valid = '0; HRESP = 1'b1; HREADY = 1'b0; #1;
    chk("t5_err1_htrans", HTRANS, 2'b10);
    tick();
    req_valid = 4'b0001; HREADY = 1'b1; #1;
    chk("t5_err2_htrans", {HTRANS, HADDR}, {2'b00, 32'h300});
    chk("t5_err2_ready", req_ready, '0);
    chk("t5_err2_no_rsp", rsp_valid, '0);
    tick();
    req_valid = '0; HRESP = 1'b0; #1;
    chk("t5_err_rsp", {rsp_valid, rsp_err}, {4'b0100, 1'b1});
    chk("t5_reissue", {HTRANS, HADDR, HWRITE, HSIZE}, {2'b10, 32'h300, 1'b1, 3'd1});
    tick();
    chk("t5_req3_hwdata", HWDATA, 32'h33);
    tick();
    chk("t5_req3_rsp", {rsp_valid, rsp_err}, {4'b1000, 1'b0});

    // T6: reset with both pipeline stages occupied
    req_valid = 4'b1111;
    tick(); tick();
    HRESET = 1'b1; #1;
    chk("t6_ready_in_rst", req_ready, '0);
    tick();
    HRESET = 1'b0; #1;
    chk("t6_idle", {HTRANS, rsp_valid}, {2'b00, 4'b0000});
    chk("t6_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    tick();
    chk("t6_no_rsp", {HTRANS, rsp_valid}, {2'b00, 4'b0000});

    // Randomized run against a transaction-level model
    reset_dut();
    ptr = 0; a_s.v = 1'b0; d_s.v = 1'b0; er.v = 1'b0; m_hold = 1'b0; errst = 0;
    for (int i = 0; i < N; i++) pend[i].v = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i].v && $urandom_range(0, 2) == 0) begin
          pend[i].v     = 1'b1;
          pend[i].owner = i;
          pend[i].wr    = 1'($urandom_range(0, 1));
          pend[i].addr  = $urandom;
          pend[i].wdata = $urandom;
          pend[i].size  = 3'($urandom_range(0, 2));
        end
        req_valid[i] = pend[i].v;
        set_req(i, pend[i].wr, pend[i].addr, pend[i].wdata, pend[i].size);
      end
      HRDATA = $urandom;
      if (errst == 1) begin
        HRESP = 1'b1; HREADY = 1'b1; errst = 0;
      end else if (d_s.v && $urandom_range(0, 7) == 0) begin
        HRESP = 1'b1; HREADY = 1'b0; errst = 1;
      end else begin
        HRESP = 1'b0; HREADY = ($urandom_range(0, 3) != 0);
      end
      #1;
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && pend[(ptr + k) % N].v) win = (ptr + k) % N;
      exp_ready = (HREADY && !m_hold && win >= 0) ? N'(1 << win) : '0;
      chk("rnd_ready", req_ready, exp_ready);
      chk("rnd_htrans", HTRANS, (a_s.v && !m_hold) ? 2'b10 : 2'b00);
      if (a_s.v && !m_hold)
        chk("rnd_addr_phase", {HADDR, HWRITE, HSIZE}, {a_s.addr, a_s.wr, a_s.size});
      if (d_s.v && d_s.wr) chk("rnd_hwdata", HWDATA, d_s.wdata);
      chk("rnd_rsp_valid", rsp_valid, er.v ? N'(1 << er.owner) : '0);
      if (er.v) chk("rnd_rsp_data", {rsp_err, rsp_rdata}, {er.err, er.rdata});

      nxt.v = 1'b0; nxt.owner = 0; nxt.rdata = '0; nxt.err = 1'b0;
      if (HREADY) begin
        if (d_s.v) begin
          nxt.v = 1'b1; nxt.owner = d_s.owner;
          nxt.rdata = d_s.wr ? '0 : HRDATA; nxt.err = HRESP;
        end
        if (HRESP && d_s.v) begin
          d_s.v = 1'b0;
        end else begin
          d_s = a_s;
          a_s.v = 1'b0;
          if (exp_ready != '0) begin
            a_s = pend[win];
            pend[win].v = 1'b0;
            ptr = (win + 1) % N;
          end
        end
        m_hold = 1'b0;
      end else if (HRESP && d_s.v) begin
        m_hold = 1'b1;
      end
      er = nxt;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
`default_nettype wire
